tz_zone_sequencer: RTL and testbench

- Controller for the time-zone hour-offset datapath in the alarm clock.
- Selects which zone's hour is shown: manually, by stepping with a debounced button, or automatically in a scan mode that rotates zones every DWELL_SEC seconds.
- Registers the zone-adjusted hour with correct modulo-24 wrap and a day-carry flag.
- Sits between the timekeeping counter (hour_in, 1 Hz tick) and the display/alarm compare logic.

---
 rtl/tz_pkg.sv | 23 ++
 rtl/tz_debounce.sv | 41 ++++
 rtl/tz_zone_sequencer.sv | 134 +++++++++++++
 tb/tb_tz_zone_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tz_pkg.sv
// Shared constants, zone offset table and FSM state type for the time-zone sequencer.
package tz_pkg;

    localparam int unsigned NUM_ZONES     = 5;
    localparam int unsigned HOURS_PER_DAY = 24;

    // Hour offsets: home, Halifax, Sao Paulo, Milan, Dubai.
    localparam logic [5:0] ZONE_OFFSET [0:NUM_ZONES-1] = '{6'd0, 6'd1, 6'd3, 6'd6, 6'd9};

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } tz_state_e;

    // Out-of-range indices fall back to the home zone offset.
    function automatic logic [5:0] zone_offset(input logic [2:0] idx);
        if (32'(idx) >= NUM_ZONES) begin
            return '0;
        end
        return ZONE_OFFSET[idx];
    endfunction

endpackage

// File: rtl/tz_debounce.sv
// Button debouncer: accepts a level change only after it has been stable for
// DEBOUNCE_CYC cycles, and emits a single-cycle pulse on each accepted press.
module tz_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_in,
    output logic o_press_pulse
);

    localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;

    // Count consecutive cycles that disagree with the accepted level; flip on the last one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (i_btn_in == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= i_btn_in;
                r_press <= i_btn_in;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press_pulse = r_press;

endmodule

// File: rtl/tz_zone_sequencer.sv
// Time-zone selector and zone-adjusted hour register for the alarm clock.
// Zones advance on a debounced button press, or automatically every DWELL_SEC
// seconds while scan mode is enabled.
module tz_zone_sequencer
    import tz_pkg::*;
#(
    parameter int unsigned NUM_ZONES    = tz_pkg::NUM_ZONES,
    parameter int unsigned DWELL_SEC    = 5,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick_1hz,
    input  logic       i_btn_next,
    input  logic       i_scan_en,
    input  logic [5:0] i_hour_in,
    output logic [2:0] o_zone_idx,
    output logic [5:0] o_hour_zone,
    output logic       o_day_wrap,
    output logic       o_hour_err,
    output logic       o_zone_chg,
    output logic       o_scanning
);

    localparam logic [5:0] DWELL_LAST = 6'(DWELL_SEC - 1);

    tz_state_e  r_state;
    logic [2:0] r_zone_idx;
    logic [5:0] r_dwell;
    logic       r_adv;
    logic       r_zone_chg;
    logic       r_scanning;
    logic [5:0] r_hour_zone;
    logic       r_day_wrap;
    logic       r_hour_err;

    logic       w_press;
    logic [2:0] w_zone_next;
    logic [5:0] w_offset;
    logic [6:0] w_sum;
    logic [5:0] w_hour_wrap;

    tz_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_btn_in     (i_btn_next),
        .o_press_pulse(w_press)
    );

    assign w_zone_next = (32'(r_zone_idx) >= NUM_ZONES - 1) ? 3'd0 : r_zone_idx + 3'd1;

    // Zone-selection FSM; r_adv marks an advance so zone_chg can follow one cycle later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= MANUAL;
            r_zone_idx <= '0;
            r_dwell    <= '0;
            r_adv      <= 1'b0;
            r_zone_chg <= 1'b0;
            r_scanning <= 1'b0;
        end else begin
            r_adv      <= 1'b0;
            r_zone_chg <= r_adv;
            case (r_state)
                MANUAL: begin
                    if (w_press) begin
                        r_zone_idx <= w_zone_next;
                        r_adv      <= 1'b1;
                    end
                    if (i_scan_en) begin
                        r_state    <= SCAN;
                        r_dwell    <= '0;
                        r_scanning <= 1'b1;
                    end
                end
                SCAN: begin
                    // Leaving scan mode wins over a coincident dwell expiry.
                    if (!i_scan_en) begin
                        r_state    <= MANUAL;
                        r_dwell    <= '0;
                        r_scanning <= 1'b0;
                    end else if (w_press) begin
                        r_zone_idx <= w_zone_next;
                        r_adv      <= 1'b1;
                        r_dwell    <= '0;
                    end else if (i_tick_1hz) begin
                        if (r_dwell == DWELL_LAST) begin
                            r_zone_idx <= w_zone_next;
                            r_adv      <= 1'b1;
                            r_dwell    <= '0;
                        end else begin
                            r_dwell <= r_dwell + 6'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign w_offset    = zone_offset(r_zone_idx);
    assign w_sum       = {1'b0, i_hour_in} + {1'b0, w_offset};
    assign w_hour_wrap = 6'(w_sum - 7'(HOURS_PER_DAY));

    // Register the zone-adjusted hour with modulo-24 wrap and day-carry every cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hour_zone <= '0;
            r_day_wrap  <= 1'b0;
            r_hour_err  <= 1'b0;
        end else if (i_hour_in > 6'(HOURS_PER_DAY - 1)) begin
            r_hour_zone <= '0;
            r_day_wrap  <= 1'b0;
            r_hour_err  <= 1'b1;
        end else if (w_sum >= 7'(HOURS_PER_DAY)) begin
            r_hour_zone <= w_hour_wrap;
            r_day_wrap  <= 1'b1;
            r_hour_err  <= 1'b0;
        end else begin
            r_hour_zone <= w_sum[5:0];
            r_day_wrap  <= 1'b0;
            r_hour_err  <= 1'b0;
        end
    end

    assign o_zone_idx  = r_zone_idx;
    assign o_hour_zone = r_hour_zone;
    assign o_day_wrap  = r_day_wrap;
    assign o_hour_err  = r_hour_err;
    assign o_zone_chg  = r_zone_chg;
    assign o_scanning  = r_scanning;

endmodule

// File: tb/tb_tz_zone_sequencer.sv
// Testbench for tz_zone_sequencer: zone changes are checked against a queue of
// expected zone indices; each scenario task also checks outputs inline.
module tb_tz_zone_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       btn;
    logic       scan_en;
    logic [5:0] hour_in;
    logic [2:0] zone_idx;
    logic [5:0] hour_zone;
    logic       day_wrap;
    logic       hour_err;
    logic       zone_chg;
    logic       scanning;

    int checks = 0;
    int errors = 0;
    int chg_cnt;

    logic [2:0] exp_q[$];
    logic [2:0] prev_zone;
    bit         exp_chg;

    tz_zone_sequencer #(
        .DWELL_SEC   (2),
        .DEBOUNCE_CYC(4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_tick_1hz (tick),
        .i_btn_next (btn),
        .i_scan_en  (scan_en),
        .i_hour_in  (hour_in),
        .o_zone_idx (zone_idx),
        .o_hour_zone(hour_zone),
        .o_day_wrap (day_wrap),
        .o_hour_err (hour_err),
        .o_zone_chg (zone_chg),
        .o_scanning (scanning)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops the expected zone on every zone_idx change; zone_chg must follow one cycle later.
    task automatic monitor();
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_zone = '0;
                exp_chg   = 1'b0;
            end else begin
                checks++;
                if (zone_chg !== exp_chg) begin
                    errors++;
                    $display("FAIL zone_chg: got %0b expected %0b at %0t", zone_chg, exp_chg, $time);
                end
                if (zone_idx !== prev_zone) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL zone_unexpected: got %0d with no change expected at %0t", zone_idx, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (zone_idx !== e) begin
                            errors++;
                            $display("FAIL zone_seq: got %0d expected %0d at %0t", zone_idx, e, $time);
                        end
                    end
                    exp_chg = 1'b1;
                end else begin
                    exp_chg = 1'b0;
                end
                prev_zone = zone_idx;
            end
        end
    endtask

    task automatic press_btn();
        btn = 1'b1;
        repeat (5) step();
        btn = 1'b0;
        repeat (5) step();
    endtask

    task automatic tick_once();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic drive_btn(input logic v, input int n);
        btn = v;
        repeat (n) begin
            step();
            if (zone_chg === 1'b1) chg_cnt++;
        end
    endtask

    task automatic test_reset();
        exp_q.push_back(3'd1); press_btn();
        exp_q.push_back(3'd2); press_btn();
        exp_q.push_back(3'd3); press_btn();
        hour_in = 6'd10;
        step();
        checks++;
        if ({zone_idx, hour_zone} !== {3'd3, 6'd16}) begin
            errors++;
            $display("FAIL pre_reset: got zone %0d hour %0d expected zone 3 hour 16", zone_idx, hour_zone);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({zone_idx, hour_zone, day_wrap, hour_err, zone_chg, scanning} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got zone %0d hour %0d wrap %0b err %0b chg %0b scan %0b expected all 0",
                     zone_idx, hour_zone, day_wrap, hour_err, zone_chg, scanning);
        end
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++;
        if ({zone_idx, hour_zone} !== {3'd0, 6'd10}) begin
            errors++;
            $display("FAIL post_reset: got zone %0d hour %0d expected zone 0 hour 10", zone_idx, hour_zone);
        end
    endtask

    task automatic test_debounce();
        chg_cnt = 0;
        exp_q.push_back(3'd1);
        drive_btn(1'b1, 2);
        drive_btn(1'b0, 1);
        drive_btn(1'b1, 6);
        drive_btn(1'b0, 8);
        checks++;
        if (chg_cnt !== 1 || zone_idx !== 3'd1) begin
            errors++;
            $display("FAIL debounce_glitch: got %0d pulses zone %0d expected 1 pulse zone 1", chg_cnt, zone_idx);
        end
        chg_cnt = 0;
        exp_q.push_back(3'd2);
        drive_btn(1'b1, 100);
        drive_btn(1'b0, 8);
        checks++;
        if (chg_cnt !== 1 || zone_idx !== 3'd2) begin
            errors++;
            $display("FAIL debounce_hold: got %0d pulses zone %0d expected 1 pulse zone 2", chg_cnt, zone_idx);
        end
    endtask

    task automatic test_wrap();
        // {zone advance before?, hour_in, expected hour_zone, day_wrap, hour_err}
        logic       adv  [0:8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0] zn   [0:8] = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0};
        logic [5:0] hin  [0:8] = '{6'd17, 6'd30, 6'd17, 6'd20, 6'd15, 6'd23, 6'd24, 6'd23, 6'd0};
        logic [5:0] hexp [0:8] = '{6'd23, 6'd0, 6'd23, 6'd5, 6'd0, 6'd8, 6'd0, 6'd23, 6'd0};
        logic       wexp [0:8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       eexp [0:8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            if (adv[i]) begin
                exp_q.push_back(zn[i]);
                press_btn();
            end
            hour_in = hin[i];
            step();
            checks++;
            if ({zone_idx, hour_zone, day_wrap, hour_err} !== {zn[i], hexp[i], wexp[i], eexp[i]}) begin
                errors++;
                $display("FAIL wrap_%0d: got zone %0d hour %0d wrap %0b err %0b expected zone %0d hour %0d wrap %0b err %0b",
                         i, zone_idx, hour_zone, day_wrap, hour_err, zn[i], hexp[i], wexp[i], eexp[i]);
            end
        end
    endtask

    task automatic test_scan();
        logic [2:0] e;
        scan_en = 1'b1;
        step();
        checks++;
        if ({scanning, zone_idx} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL scan_enter: got scan %0b zone %0d expected scan 1 zone 0", scanning, zone_idx);
        end
        for (int k = 1; k <= 5; k++) exp_q.push_back(3'(k % 5));
        for (int k = 1; k <= 10; k++) begin
            tick_once();
            e = 3'((k / 2) % 5);
            checks++;
            if ({scanning, zone_idx} !== {1'b1, e}) begin
                errors++;
                $display("FAIL scan_tick_%0d: got scan %0b zone %0d expected scan 1 zone %0d", k, scanning, zone_idx, e);
            end
        end
    endtask

    task automatic test_collision();
        tick_once();
        checks++;
        if (zone_idx !== 3'd0) begin
            errors++;
            $display("FAIL coll_pre: got zone %0d expected 0", zone_idx);
        end
        exp_q.push_back(3'd1);
        btn = 1'b1;
        repeat (4) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        checks++;
        if (zone_idx !== 3'd1) begin
            errors++;
            $display("FAIL coll_once: got zone %0d expected 1", zone_idx);
        end
        tick_once();
        checks++;
        if (zone_idx !== 3'd1) begin
            errors++;
            $display("FAIL coll_dwell_restart: got zone %0d expected 1", zone_idx);
        end
        exp_q.push_back(3'd2);
        tick_once();
        checks++;
        if (zone_idx !== 3'd2) begin
            errors++;
            $display("FAIL coll_next: got zone %0d expected 2", zone_idx);
        end
        btn = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_mode_exit();
        tick_once();
        scan_en = 1'b0;
        tick    = 1'b1;
        step();
        tick = 1'b0;
        checks++;
        if ({scanning, zone_idx} !== {1'b0, 3'd2}) begin
            errors++;
            $display("FAIL exit_expiry: got scan %0b zone %0d expected scan 0 zone 2", scanning, zone_idx);
        end
        repeat (4) tick_once();
        checks++;
        if ({scanning, zone_idx} !== {1'b0, 3'd2}) begin
            errors++;
            $display("FAIL exit_ticks: got scan %0b zone %0d expected scan 0 zone 2", scanning, zone_idx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        tick    = 1'b0;
        btn     = 1'b0;
        scan_en = 1'b0;
        hour_in = 6'd0;
        fork
            monitor();
        join_none
        repeat (2) step();
        rst = 1'b0;
        step();
        test_reset();
        test_debounce();
        test_wrap();
        test_scan();
        test_collision();
        test_mode_exit();
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending zone changes expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
